bp_network_flit_arbiter: RTL and testbench
==========================================

# bp_network_flit_arbiter

Round-robin arbiter that shares one `bp_network_deserializer` input port among several flit-producing channels. It grants whole messages (`num_packets_p` flits) to one requester at a time, so flits from different channels never interleave within a message. It registers the selected flit into a one-entry output stage that drives the deserializer's `v_i`/`data_i`, using the deserializer's `ready_o` as backpressure.

## Interface
- `num_in_p`, 4, number of requesting flit channels (≥1)
- `num_dest`, "inv", destination count; sets `dest_id_width_p = BSG_SAFE_CLOG2(num_dest)`
- `num_src`, "inv", source count; sets `src_id_width_p = BSG_SAFE_CLOG2(num_src)`
- `packet_data_width_p`, "inv", payload bits per flit
- `num_packets_p`, 4, flits per message (≥1)
- `lock_p`, 1, 1 = hold grant for a whole message; 0 = rotate every flit
- derived `flit_width_p = packet_data_width_p + dest_id_width_p + src_id_width_p`

Ports:
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `v_i`  in  num_in_p  per-channel flit valid
- `data_i`  in  num_in_p*flit_width_p  channel i at `[i*flit_width_p +: flit_width_p]`
- `ready_o`  out  num_in_p  per-channel accept; transfer on `v_i[i] & ready_o[i]`
- `v_o`  out  1  output flit valid
- `data_o`  out  flit_width_p  output flit (deserializer format)
- `ready_i`  in  1  downstream accept; transfer on `v_o & ready_i`
- `grant_id_o`  out  BSG_SAFE_CLOG2(num_in_p)  owner of current/last grant
- `locked_o`  out  1  high while in LOCKED

## Operation
- State: `IDLE`, `LOCKED`; `rr_ptr` (highest-priority index); `owner`; `flit_cnt` (BSG_SAFE_CLOG2(num_packets_p) bits).
- `out_free = ~v_o | ready_i`.
- IDLE: winner is the first `i` with `v_i[i]` scanning from `rr_ptr` upward, modulo `num_in_p`. `ready_o[winner] = out_free`; all other bits are 0.
- IDLE transfer:
  - if `lock_p` and `num_packets_p > 1`: go to LOCKED, `owner <= winner`, `flit_cnt <= 1`.
  - otherwise: `rr_ptr <= winner+1` (wraps `num_in_p-1` to 0), `owner <= winner`.
- LOCKED: only `ready_o[owner] = out_free`. Other channels wait even if owner's `v_i` is low (bubble; no fallback).
- LOCKED transfer: `flit_cnt++`. On the transfer with `flit_cnt == num_packets_p-1`: go to IDLE, `flit_cnt <= 0`, `rr_ptr <= owner+1` mod `num_in_p`.
- Output stage: on input transfer, `v_o <= 1`, `data_o <= data_i[winner]`. Otherwise, if `ready_i`, `v_o <= 0`. While `v_o & ~ready_i`, `data_o` is held stable.
- `ready_o` is a combinational function of `v_i`, state and `ready_i`. `ready_o` never depends on `data_i`.

## Timing
- Reset values: `v_o=0`, `data_o=0`, `ready_o=0` (no `v_i`), `grant_id_o=0`, `locked_o=0`, IDLE, `rr_ptr=0`, `flit_cnt=0`.
- Latency: input transfer in cycle N gives `v_o=1` in N+1. Throughput is 1 flit/cycle with `ready_i` held high.
- Simultaneous output drain and new input transfer in the same cycle: `v_o` stays 1 with the new data.
- `num_in_p==1`: `rr_ptr` is constantly 0. `num_packets_p==1`: LOCKED is never entered.
- Reset asserted mid-message clears all state and drops any partial message. The deserializer must be reset on the same reset so its per-source counts stay consistent.
- Requesters must hold `v_i`/`data_i` until accepted. The arbiter does not check this.

## Structure
- `bp_network_pkg`:
  - flit-width helper: `dest+src+packet` widths
  - `bp_network_arb_state_e {e_arb_idle, e_arb_locked}`
- Sub-module `bp_network_rr_picker`: combinational rotate-priority picker. Inputs are `req[num_in_p]` and `rr_ptr`; outputs are one-hot grant plus encoded index and `any_v`.
- Top-level holds the FSM, counter and output register. Top-level plus picker is about 150–250 lines.

## Test plan
Configuration for all tests: `num_in_p=3`, `num_packets_p=2`, `lock_p=1`, `ready_i=1` unless noted.
- **Reset:** all `v_i=1`, reset low → `v_o=0`, `ready_o=0`. After reset release: `ready_o=3'b001`, `v_o` rises next cycle.
- **Message fairness:** all `v_i=1` → output order ch0,ch0,ch1,ch1,ch2,ch2,ch0; `locked_o` high on each second flit's acceptance cycle.
- **Owner bubble:** ch1 owns lock, drops `v_i[1]` after flit 0 for 3 cycles while ch2 is valid → `ready_o=0`, `v_o=0` for those cycles; ch1 flit 1 goes next, then ch2.
- **Backpressure:** `ready_i=0` for 4 cycles with `v_o=1` → `data_o` is stable and `ready_o=0`. `ready_i` back to 1 → drains, and 1 new flit is accepted in the same cycle.
- **Wrap:** only ch2 requests, then only ch0 → `rr_ptr` goes 0→0 (after ch2 message wraps), ch0 is granted immediately.
- **Reset mid-message:** reset after ch0 flit 0 → after release `locked_o=0`, `rr_ptr=0`, `flit_cnt=0`.

Source files
------------

// File: rtl/bp_network_pkg.sv
// bp_network_pkg: shared widths, helpers and arbiter state encoding for the bp network blocks
package bp_network_pkg;

  typedef enum logic {e_arb_idle, e_arb_locked} bp_network_arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int flit_width(input int num_dest, input int num_src, input int packet_data_width);
    return packet_data_width + safe_clog2(num_dest) + safe_clog2(num_src);
  endfunction

endpackage

// File: rtl/bp_network_rr_picker.sv
// bp_network_rr_picker: combinational rotate-priority picker, first request at or above rr_ptr wins
module bp_network_rr_picker
  import bp_network_pkg::*;
#(
  parameter int num_in_p = 4,
  localparam int iw_lp = safe_clog2(num_in_p)
) (
  input  logic [num_in_p-1:0] req,
  input  logic [iw_lp-1:0]    rr_ptr,
  output logic [num_in_p-1:0] grant,
  output logic [iw_lp-1:0]    idx,
  output logic                any_v
);

  // Scan from farthest to nearest so the request closest to rr_ptr is written last
  always_comb begin
    idx = '0;
    for (int k = num_in_p - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= num_in_p) j = j - num_in_p;
      if (req[j]) idx = iw_lp'(j);
    end
  end

  assign any_v = |req;
  assign grant = any_v ? (num_in_p'(1) << idx) : '0;

endmodule

// File: rtl/bp_network_flit_arbiter.sv
// bp_network_flit_arbiter: round-robin message arbiter feeding one deserializer port through a
// one-entry output register; reset_i is asynchronous and active-low
module bp_network_flit_arbiter
  import bp_network_pkg::*;
#(
  parameter int num_in_p            = 4,
  parameter int num_dest            = 4,
  parameter int num_src             = 4,
  parameter int packet_data_width_p = 8,
  parameter int num_packets_p       = 4,
  parameter int lock_p              = 1,
  localparam int flit_width_p = flit_width(num_dest, num_src, packet_data_width_p),
  localparam int iw_lp = safe_clog2(num_in_p),
  localparam int cw_lp = safe_clog2(num_packets_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_in_p-1:0]              v_i,
  input  logic [num_in_p*flit_width_p-1:0] data_i,
  output logic [num_in_p-1:0]              ready_o,
  output logic                             v_o,
  output logic [flit_width_p-1:0]          data_o,
  input  logic                             ready_i,
  output logic [iw_lp-1:0]                 grant_id_o,
  output logic                             locked_o
);

  localparam bit lock_en_lp = (lock_p != 0) && (num_packets_p > 1);

  bp_network_arb_state_e state, state_n;
  logic [iw_lp-1:0] rr_ptr, rr_ptr_n, owner, owner_n, win_idx, sel;
  logic [cw_lp-1:0] flit_cnt, flit_cnt_n;
  logic [num_in_p-1:0] win_grant;
  logic any_v, out_free, locked, xfer;

  function automatic logic [iw_lp-1:0] nxt(input logic [iw_lp-1:0] i);
    return (i == iw_lp'(num_in_p - 1)) ? '0 : i + 1'b1;
  endfunction

  bp_network_rr_picker #(.num_in_p(num_in_p)) picker (
    .req    (v_i),
    .rr_ptr (rr_ptr),
    .grant  (win_grant),
    .idx    (win_idx),
    .any_v  (any_v)
  );

  assign locked     = state == e_arb_locked;
  assign locked_o   = locked;
  assign grant_id_o = owner;
  assign out_free   = ~v_o | ready_i;
  assign sel        = locked ? owner : win_idx;
  // While locked the owner alone may transfer; other channels wait through any bubble
  assign ready_o = ~reset_i ? '0
                 : locked   ? ((v_i[owner] & out_free) ? (num_in_p'(1) << owner) : '0)
                 :            ((any_v & out_free) ? win_grant : '0);
  assign xfer = |(v_i & ready_o);

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    flit_cnt_n = flit_cnt;
    if (xfer && !locked) begin
      owner_n = win_idx;
      if (lock_en_lp) begin
        state_n    = e_arb_locked;
        flit_cnt_n = cw_lp'(1);
      end else rr_ptr_n = nxt(win_idx);
    end else if (xfer) begin
      if (flit_cnt == cw_lp'(num_packets_p - 1)) begin
        state_n    = e_arb_idle;
        flit_cnt_n = '0;
        rr_ptr_n   = nxt(owner);
      end else flit_cnt_n = flit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= e_arb_idle;
      rr_ptr   <= '0;
      owner    <= '0;
      flit_cnt <= '0;
      v_o      <= 1'b0;
      data_o   <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      flit_cnt <= flit_cnt_n;
      if (xfer) begin
        v_o    <= 1'b1;
        data_o <= data_i[sel*flit_width_p +: flit_width_p];
      end else if (ready_i) v_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_network_flit_arbiter.sv
// tb_bp_network_flit_arbiter: directed scenarios for the 3-channel, 2-flit locked arbiter
module tb_bp_network_flit_arbiter;

  localparam int fw = 12;

  logic clk_i = 0;
  logic reset_i;
  logic [2:0] v_i;
  logic [3*fw-1:0] data_i;
  logic [2:0] ready_o;
  logic v_o;
  logic [fw-1:0] data_o;
  logic ready_i;
  logic [1:0] grant_id_o;
  logic locked_o;

  int ncmp = 0;
  int nerr = 0;
  int seq[3] = '{0, 0, 0};

  always #5 clk_i = ~clk_i;

  bp_network_flit_arbiter #(
    .num_in_p(3), .num_dest(4), .num_src(4), .packet_data_width_p(8),
    .num_packets_p(2), .lock_p(1)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .ready_i(ready_i), .grant_id_o(grant_id_o), .locked_o(locked_o)
  );

  function automatic logic [fw-1:0] dat(input int ch, input int n);
    return {4'(ch), 8'(n)};
  endfunction

  task automatic upd();
    data_i = {dat(2, seq[2]), dat(1, seq[1]), dat(0, seq[0])};
  endtask

  // Each requester presents its next flit after its current one is accepted
  task automatic step();
    logic [2:0] acc;
    acc = v_i & ready_o;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) if (acc[i]) seq[i]++;
    upd();
    #1;
  endtask

  task automatic test_reset();
    reset_i = 0; v_i = 3'b111; ready_i = 1; upd();
    step(); step();
    ncmp++; if (v_o !== 1'b0) begin nerr++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    ncmp++; if (ready_o !== 3'b000) begin nerr++; $display("FAIL reset_ready_o: got %b want 000", ready_o); end
    ncmp++; if (data_o !== 12'h000) begin nerr++; $display("FAIL reset_data_o: got %h want 000", data_o); end
    reset_i = 1; #1;
    ncmp++; if (ready_o !== 3'b001) begin nerr++; $display("FAIL release_ready_o: got %b want 001", ready_o); end
    ncmp++; if (locked_o !== 1'b0) begin nerr++; $display("FAIL release_locked_o: got %b want 0", locked_o); end
    ncmp++; if (grant_id_o !== 2'd0) begin nerr++; $display("FAIL release_grant_id: got %0d want 0", grant_id_o); end
  endtask

  task automatic test_fairness();
    logic [2:0] er[8] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
    logic [fw-1:0] ed[8] = '{12'h000, 12'h001, 12'h100, 12'h101, 12'h200, 12'h201, 12'h002, 12'h003};
    for (int k = 0; k < 8; k++) begin
      ncmp++; if (ready_o !== er[k]) begin nerr++; $display("FAIL fair_ready[%0d]: got %b want %b", k, ready_o, er[k]); end
      ncmp++; if (locked_o !== 1'(k % 2)) begin nerr++; $display("FAIL fair_locked[%0d]: got %b want %0d", k, locked_o, k % 2); end
      step();
      ncmp++; if ({v_o, data_o} !== {1'b1, ed[k]}) begin nerr++; $display("FAIL fair_data[%0d]: got v=%b %h want v=1 %h", k, v_o, data_o, ed[k]); end
    end
    v_i = 3'b000; step();
    ncmp++; if (v_o !== 1'b0) begin nerr++; $display("FAIL fair_drain_v_o: got %b want 0", v_o); end
  endtask

  task automatic test_bubble();
    v_i = 3'b110; #1;
    ncmp++; if (ready_o !== 3'b010) begin nerr++; $display("FAIL bub_first_ready: got %b want 010", ready_o); end
    step();
    ncmp++; if (data_o !== 12'h102) begin nerr++; $display("FAIL bub_first_data: got %h want 102", data_o); end
    v_i = 3'b100; #1;
    for (int k = 0; k < 3; k++) begin
      ncmp++; if (ready_o !== 3'b000) begin nerr++; $display("FAIL bub_ready[%0d]: got %b want 000", k, ready_o); end
      step();
      ncmp++; if (v_o !== 1'b0) begin nerr++; $display("FAIL bub_v_o[%0d]: got %b want 0", k, v_o); end
    end
    v_i = 3'b110; #1;
    ncmp++; if (ready_o !== 3'b010) begin nerr++; $display("FAIL bub_resume_ready: got %b want 010", ready_o); end
    step();
    ncmp++; if (data_o !== 12'h103) begin nerr++; $display("FAIL bub_resume_data: got %h want 103", data_o); end
    ncmp++; if (ready_o !== 3'b100) begin nerr++; $display("FAIL bub_next_ready: got %b want 100", ready_o); end
    step();
    ncmp++; if (data_o !== 12'h202) begin nerr++; $display("FAIL bub_ch2_f0: got %h want 202", data_o); end
    step();
    ncmp++; if (data_o !== 12'h203) begin nerr++; $display("FAIL bub_ch2_f1: got %h want 203", data_o); end
    v_i = 3'b000; step();
  endtask

  task automatic test_backpressure();
    v_i = 3'b001; #1;
    step();
    ncmp++; if ({v_o, data_o} !== {1'b1, 12'h004}) begin nerr++; $display("FAIL bp_first: got v=%b %h want v=1 004", v_o, data_o); end
    ready_i = 0; #1;
    for (int k = 0; k < 4; k++) begin
      ncmp++; if (ready_o !== 3'b000) begin nerr++; $display("FAIL bp_ready[%0d]: got %b want 000", k, ready_o); end
      step();
      ncmp++; if ({v_o, data_o} !== {1'b1, 12'h004}) begin nerr++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 004", k, v_o, data_o); end
    end
    ready_i = 1; #1;
    ncmp++; if (ready_o !== 3'b001) begin nerr++; $display("FAIL bp_release_ready: got %b want 001", ready_o); end
    step();
    ncmp++; if ({v_o, data_o} !== {1'b1, 12'h005}) begin nerr++; $display("FAIL bp_drain_accept: got v=%b %h want v=1 005", v_o, data_o); end
    v_i = 3'b000; step();
  endtask

  task automatic test_wrap();
    v_i = 3'b100; #1;
    ncmp++; if (ready_o !== 3'b100) begin nerr++; $display("FAIL wrap_ch2_ready: got %b want 100", ready_o); end
    step(); step();
    ncmp++; if (data_o !== 12'h205) begin nerr++; $display("FAIL wrap_ch2_data: got %h want 205", data_o); end
    ncmp++; if (dut.rr_ptr !== 2'd0) begin nerr++; $display("FAIL wrap_rr_ptr: got %0d want 0", dut.rr_ptr); end
    v_i = 3'b001; #1;
    ncmp++; if (ready_o !== 3'b001) begin nerr++; $display("FAIL wrap_ch0_ready: got %b want 001", ready_o); end
    step();
    ncmp++; if (data_o !== 12'h006) begin nerr++; $display("FAIL wrap_ch0_data: got %h want 006", data_o); end
    step();
    v_i = 3'b000; step();
  endtask

  task automatic test_reset_mid();
    v_i = 3'b001; #1;
    step();
    ncmp++; if ({locked_o, data_o} !== {1'b1, 12'h008}) begin nerr++; $display("FAIL mid_pre: got lock=%b %h want lock=1 008", locked_o, data_o); end
    reset_i = 0; #1;
    ncmp++; if (locked_o !== 1'b0) begin nerr++; $display("FAIL mid_locked: got %b want 0", locked_o); end
    ncmp++; if (dut.rr_ptr !== 2'd0) begin nerr++; $display("FAIL mid_rr_ptr: got %0d want 0", dut.rr_ptr); end
    ncmp++; if (dut.flit_cnt !== 1'd0) begin nerr++; $display("FAIL mid_flit_cnt: got %0d want 0", dut.flit_cnt); end
    ncmp++; if ({v_o, data_o} !== 13'h0) begin nerr++; $display("FAIL mid_out: got v=%b %h want v=0 000", v_o, data_o); end
    step();
    reset_i = 1; #1;
    ncmp++; if ({locked_o, ready_o} !== 4'b0001) begin nerr++; $display("FAIL mid_release: got lock=%b ready=%b want lock=0 ready=001", locked_o, ready_o); end
    v_i = 3'b000;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_bubble();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
